// File: rtl/garo_pkg.sv
// Shared constants, types and helpers for the GARO true random number generator.
package garo_pkg;

  localparam logic [30:0] GARO_DEFAULT_TAPS = 31'h4A3B_E75A;

  typedef enum logic {
    DEBIAS_OFF = 1'b0,
    DEBIAS_VN  = 1'b1
  } debias_e;

  // Counter width able to hold the repetition limit itself.
  function automatic int rct_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/garo_osc_cell.sv
// One free-running Galois ring oscillator; all stages are forced low while stop=1.
module garo_osc_cell
  import garo_pkg::*;
#(
  parameter int                 OSC_LEN  = 31,
  parameter logic [OSC_LEN-1:0] OSC_TAPS = OSC_LEN'(GARO_DEFAULT_TAPS)
) (
  input  logic stop,
  output logic osc_out
);

  (* keep = "true" *) logic fb;

  // The ring only closes in the synthesised netlist; simulation sees an open chain.
`ifdef SYNTHESIS
  assign fb = g_stage[OSC_LEN-1].q;
`else
  assign fb = 1'b0;
`endif

  for (genvar k = 0; k < OSC_LEN; k++) begin : g_stage
    (* keep = "true" *) logic q;
    if (k == 0) begin : g_head
      assign q = ~stop & ~fb;
    end else if (OSC_TAPS[k]) begin : g_tap
      assign q = ~stop & ~(g_stage[k-1].q ^ fb);
    end else begin : g_plain
      assign q = ~stop & ~g_stage[k-1].q;
    end
  end

  assign osc_out = g_stage[OSC_LEN-1].q;

endmodule

// File: rtl/garo_trng_core.sv
// Multi-cell GARO TRNG: synchronise, XOR-combine, debias, health-test and pack
// raw bits into words delivered over a valid/ready interface.
module garo_trng_core
  import garo_pkg::*;
#(
  parameter int                 N_OSC     = 4,
  parameter int                 OSC_LEN   = 31,
  parameter logic [OSC_LEN-1:0] OSC_TAPS  = OSC_LEN'(GARO_DEFAULT_TAPS),
  parameter int                 WORD_W    = 8,
  parameter int                 DEBIAS    = 1,
  parameter int                 RCT_LIMIT = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              test_mode,
  input  logic              test_bit,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              health_fail
);

  localparam int                RCT_W       = rct_width(RCT_LIMIT);
  localparam int                CNT_W       = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WORD_W - 1);
  localparam logic [RCT_W-1:0]  RCT_MAX     = RCT_W'(RCT_LIMIT);
  localparam debias_e           DEBIAS_MODE = (DEBIAS != 0) ? DEBIAS_VN : DEBIAS_OFF;

  logic             osc_stop;
  logic [N_OSC-1:0] osc_raw;

  assign osc_stop = ~enable;

  for (genvar g = 0; g < N_OSC; g++) begin : g_osc
    garo_osc_cell #(
      .OSC_LEN  (OSC_LEN),
      .OSC_TAPS (OSC_TAPS)
    ) u_cell (
      .stop    (osc_stop),
      .osc_out (osc_raw[g])
    );
  end

  logic [N_OSC-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  logic              raw1_q, raw1_d, raw_bit_q, raw_bit_d;
  logic [1:0]        warm_q, warm_d;
  logic              pair_q, pair_d, pair_a_q, pair_a_d;
  logic              rct_prev_q, rct_prev_d;
  logic [RCT_W-1:0]  rct_cnt_q, rct_cnt_d;
  logic              health_q, health_d;
  logic [WORD_W-1:0] acc_q, acc_d, acc_next;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              acc_full_q, acc_full_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  logic comb_bit, src_bit, raw_valid, emit, emit_bit;
  logic vis_valid, consume, out_free;

  always_comb begin
    sync1_d   = osc_raw;
    sync2_d   = sync1_q;
    comb_bit  = ^sync2_q;
    src_bit   = test_mode ? test_bit : comb_bit;
    raw1_d    = src_bit;
    raw_bit_d = raw1_q;

    // Two cycles of warm-up after enable flush whatever sat in the raw pipe.
    raw_valid = enable && (warm_q == 2'd2);
    if (!enable)              warm_d = 2'd0;
    else if (warm_q == 2'd2)  warm_d = 2'd2;
    else                      warm_d = warm_q + 2'd1;

    pair_d   = pair_q;
    pair_a_d = pair_a_q;
    emit     = 1'b0;
    emit_bit = raw_bit_q;
    if (!enable) begin
      pair_d = 1'b0;
    end else if (raw_valid) begin
      if (DEBIAS_MODE == DEBIAS_OFF) begin
        emit = 1'b1;
      end else if (!pair_q) begin
        pair_d   = 1'b1;
        pair_a_d = raw_bit_q;
      end else begin
        pair_d   = 1'b0;
        emit     = (pair_a_q != raw_bit_q);
        emit_bit = pair_a_q;
      end
    end

    rct_prev_d = rct_prev_q;
    rct_cnt_d  = rct_cnt_q;
    health_d   = health_q;
    if (!enable) begin
      rct_cnt_d = '0;
      health_d  = 1'b0;
    end else if (raw_valid) begin
      rct_prev_d = raw_bit_q;
      if ((rct_cnt_q == '0) || (raw_bit_q != rct_prev_q)) rct_cnt_d = RCT_W'(1);
      else if (rct_cnt_q != RCT_MAX)                       rct_cnt_d = rct_cnt_q + RCT_W'(1);
      if (rct_cnt_d == RCT_MAX) health_d = 1'b1;
    end

    vis_valid  = valid_q && !health_q;
    consume    = vis_valid && rnd_ready;
    out_free   = !vis_valid || rnd_ready;
    acc_next   = {acc_q[WORD_W-2:0], emit_bit};
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    acc_full_d = acc_full_q;
    data_d     = data_q;
    valid_d    = consume ? 1'b0 : valid_q;

    // A full accumulator ignores new bits until the output register frees.
    if (!enable || health_q) begin
      acc_d      = '0;
      bit_cnt_d  = '0;
      acc_full_d = 1'b0;
      if (health_q) valid_d = 1'b0;
    end else if (acc_full_q) begin
      if (out_free) begin
        data_d     = acc_q;
        valid_d    = 1'b1;
        acc_d      = '0;
        acc_full_d = 1'b0;
      end
    end else if (emit) begin
      acc_d = acc_next;
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (out_free) begin
          data_d  = acc_next;
          valid_d = 1'b1;
          acc_d   = '0;
        end else begin
          acc_full_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      raw1_q     <= 1'b0;
      raw_bit_q  <= 1'b0;
      warm_q     <= 2'd0;
      pair_q     <= 1'b0;
      pair_a_q   <= 1'b0;
      rct_prev_q <= 1'b0;
      rct_cnt_q  <= '0;
      health_q   <= 1'b0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      acc_full_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      raw1_q     <= raw1_d;
      raw_bit_q  <= raw_bit_d;
      warm_q     <= warm_d;
      pair_q     <= pair_d;
      pair_a_q   <= pair_a_d;
      rct_prev_q <= rct_prev_d;
      rct_cnt_q  <= rct_cnt_d;
      health_q   <= health_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      acc_full_q <= acc_full_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign rnd_data    = data_q;
  assign rnd_valid   = vis_valid;
  assign health_fail = health_q;

endmodule

// File: tb/tb_garo_trng_core.sv
// Scenario bench for garo_trng_core driven through test_mode with a word scoreboard.
module tb_garo_trng_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, test_mode, test_bit, rnd_ready;
  logic [7:0] rnd_data;
  logic       rnd_valid, health_fail;

  logic       en4, tm4, tb4, ready4;
  logic [3:0] rnd_data4;
  logic       rnd_valid4, health_fail4;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q  [$];
  logic [3:0] exp4_q [$];

  always #5 clk = ~clk;

  garo_trng_core dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .test_mode   (test_mode),
    .test_bit    (test_bit),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .health_fail (health_fail)
  );

  garo_trng_core #(.WORD_W(4), .DEBIAS(0)) dut4 (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (en4),
    .test_mode   (tm4),
    .test_bit    (tb4),
    .rnd_data    (rnd_data4),
    .rnd_valid   (rnd_valid4),
    .rnd_ready   (ready4),
    .health_fail (health_fail4)
  );

  task automatic drive_bit(input logic b);
    @(negedge clk);
    enable   = 1'b1;
    test_bit = b;
  endtask

  task automatic feed(input logic [63:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) drive_bit(seq[i]);
  endtask

  task automatic stop_run();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rnd_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; test_mode = 1'b1; test_bit = 1'b0; rnd_ready = 1'b1;
    en4 = 1'b0; tm4 = 1'b1; tb4 = 1'b0; ready4 = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (rnd_data !== 8'h00) begin n_miss++; $display("FAIL reset_data: got %h expected 00", rnd_data); end
    n_vec++; if (rnd_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
    n_vec++; if (health_fail !== 1'b0) begin n_miss++; $display("FAIL reset_health: got %b expected 0", health_fail); end
    n_vec++; if ({rnd_data4, rnd_valid4, health_fail4} !== 6'b0) begin
      n_miss++; $display("FAIL reset_dut4: got %h/%b/%b expected 0/0/0", rnd_data4, rnd_valid4, health_fail4);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [7:0] exp_w;
    exp_q.push_back(8'h55);
    feed(64'h6666, 16);
    repeat (2) @(negedge clk);
    n_vec++; if (rnd_valid !== 1'b0) begin n_miss++; $display("FAIL latency_early: got %b expected 0", rnd_valid); end
    @(negedge clk);
    n_vec++; if (rnd_valid !== 1'b1) begin n_miss++; $display("FAIL latency_valid: got %b expected 1", rnd_valid); end
    exp_w = exp_q.pop_front();
    n_vec++; if (rnd_data !== exp_w) begin n_miss++; $display("FAIL latency_data: got %h expected %h", rnd_data, exp_w); end
    stop_run();
  endtask

  task automatic test_equal_pairs();
    logic [3:0] pat = 4'b0011;
    logic [7:0] exp_w;
    int seen = 0;
    bit ok;
    for (int r = 0; r < 20; r++) begin
      for (int i = 3; i >= 0; i--) begin
        drive_bit(pat[i]);
        if (rnd_valid === 1'b1) seen++;
      end
    end
    n_vec++; if (seen != 0) begin n_miss++; $display("FAIL equal_pairs_words: got %0d expected 0", seen); end
    exp_q.push_back(8'hFF);
    feed(64'hAAAA, 16);
    wait_valid(8, ok);
    n_vec++; if (!ok) begin n_miss++; $display("FAIL equal_pairs_timeout: got no word expected one"); end
    exp_w = exp_q.pop_front();
    n_vec++; if (rnd_data !== exp_w) begin n_miss++; $display("FAIL equal_pairs_data: got %h expected %h", rnd_data, exp_w); end
    stop_run();
  endtask

  task automatic test_back_pressure();
    logic [15:0] p0f = 16'h55AA;
    logic [7:0]  exp_w;
    bit stable = 1'b1;
    int extra = 0;
    rnd_ready = 1'b0;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    feed(64'h6666, 16);
    feed(64'h9999, 16);
    n_vec++; if (rnd_valid !== 1'b1 || rnd_data !== exp_q[0]) begin
      n_miss++; $display("FAIL bp_first_held: got %b/%h expected 1/%h", rnd_valid, rnd_data, exp_q[0]);
    end
    for (int i = 15; i >= 0; i--) begin
      drive_bit(p0f[i]);
      if (rnd_valid !== 1'b1 || rnd_data !== 8'h55) stable = 1'b0;
    end
    n_vec++; if (!stable) begin n_miss++; $display("FAIL bp_stable: got unstable output expected 55 held"); end
    @(negedge clk);
    rnd_ready = 1'b1;
    exp_w = exp_q.pop_front();
    n_vec++; if (rnd_valid !== 1'b1 || rnd_data !== exp_w) begin
      n_miss++; $display("FAIL bp_consume_first: got %b/%h expected 1/%h", rnd_valid, rnd_data, exp_w);
    end
    @(negedge clk);
    rnd_ready = 1'b0;
    n_vec++; if (rnd_valid !== 1'b1 || rnd_data !== exp_q[0]) begin
      n_miss++; $display("FAIL bp_second_loaded: got %b/%h expected 1/%h", rnd_valid, rnd_data, exp_q[0]);
    end
    @(negedge clk);
    rnd_ready = 1'b1;
    exp_w = exp_q.pop_front();
    n_vec++; if (rnd_valid !== 1'b1 || rnd_data !== exp_w) begin
      n_miss++; $display("FAIL bp_second_data: got %b/%h expected 1/%h", rnd_valid, rnd_data, exp_w);
    end
    repeat (6) begin
      @(negedge clk);
      if (rnd_valid === 1'b1) extra++;
    end
    n_vec++; if (extra != 0) begin n_miss++; $display("FAIL bp_third_lost: got %0d words expected 0", extra); end
    stop_run();
  endtask

  task automatic test_health();
    logic [7:0] exp_w;
    bit ok;
    rnd_ready = 1'b0;
    feed(64'h6666, 16);
    for (int i = 0; i < 32; i++) begin
      drive_bit(1'b1);
      if (i == 4) begin
        n_vec++; if (rnd_valid !== 1'b1) begin n_miss++; $display("FAIL hf_pending: got %b expected 1", rnd_valid); end
      end
    end
    repeat (2) @(negedge clk);
    n_vec++; if (health_fail !== 1'b0) begin n_miss++; $display("FAIL hf_before_limit: got %b expected 0", health_fail); end
    @(negedge clk);
    n_vec++; if (health_fail !== 1'b1) begin n_miss++; $display("FAIL hf_trip: got %b expected 1", health_fail); end
    n_vec++; if (rnd_valid !== 1'b0) begin n_miss++; $display("FAIL hf_valid_forced: got %b expected 0", rnd_valid); end
    @(negedge clk);
    enable    = 1'b0;
    rnd_ready = 1'b1;
    exp_q.push_back(8'hAA);
    drive_bit(1'b1);
    n_vec++; if (health_fail !== 1'b0) begin n_miss++; $display("FAIL hf_cleared: got %b expected 0", health_fail); end
    feed(64'h1999, 15);
    wait_valid(8, ok);
    n_vec++; if (!ok) begin n_miss++; $display("FAIL hf_resume_timeout: got no word expected one"); end
    exp_w = exp_q.pop_front();
    n_vec++; if (rnd_data !== exp_w) begin n_miss++; $display("FAIL hf_resume_data: got %h expected %h", rnd_data, exp_w); end
    stop_run();
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq = 8'b1011_0110;
    logic [3:0] exp4;
    int first_k = -1, second_k = -1, words = 0;
    exp4_q.push_back(4'hB);
    exp4_q.push_back(4'h6);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rnd_valid4 === 1'b1) begin
        words++;
        if (words == 1) first_k = k;
        else if (words == 2) second_k = k;
        if (exp4_q.size() != 0) begin
          exp4 = exp4_q.pop_front();
          n_vec++; if (rnd_data4 !== exp4) begin n_miss++; $display("FAIL b2b_data: got %h expected %h", rnd_data4, exp4); end
        end
      end
      if (k < 8) begin
        en4 = 1'b1;
        tb4 = seq[7-k];
      end else if (k == 11) begin
        en4 = 1'b0;
      end
    end
    n_vec++; if (words != 2) begin n_miss++; $display("FAIL b2b_count: got %0d expected 2", words); end
    n_vec++; if (first_k != 6) begin n_miss++; $display("FAIL b2b_latency: got cycle %0d expected 6", first_k); end
    n_vec++; if (second_k - first_k != 4) begin n_miss++; $display("FAIL b2b_gap: got %0d expected 4", second_k - first_k); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_w;
    int any = 0;
    bit ok;
    feed(64'h2AA, 10);
    repeat (3) @(negedge clk);
    n_vec++; if (rnd_valid !== 1'b0) begin n_miss++; $display("FAIL rst_partial: got %b expected 0", rnd_valid); end
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    n_vec++; if (rnd_data !== 8'h00 || rnd_valid !== 1'b0) begin
      n_miss++; $display("FAIL rst_async_out: got %h/%b expected 00/0", rnd_data, rnd_valid);
    end
    n_vec++; if (rnd_data4 !== 4'h0) begin n_miss++; $display("FAIL rst_async_dut4: got %h expected 0", rnd_data4); end
    @(negedge clk);
    reset_n = 1'b1;
    feed(64'h2A, 6);
    repeat (4) begin
      @(negedge clk);
      if (rnd_valid === 1'b1) any++;
    end
    n_vec++; if (any != 0) begin n_miss++; $display("FAIL rst_no_stale_word: got %0d words expected 0", any); end
    exp_q.push_back(8'hE0);
    feed(64'h155, 10);
    wait_valid(8, ok);
    n_vec++; if (!ok) begin n_miss++; $display("FAIL rst_fresh_timeout: got no word expected one"); end
    exp_w = exp_q.pop_front();
    n_vec++; if (rnd_data !== exp_w) begin n_miss++; $display("FAIL rst_fresh_data: got %h expected %h", rnd_data, exp_w); end
    stop_run();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_equal_pairs();
    test_back_pressure();
    test_health();
    test_back_to_back();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
